i2s_apb_master: RTL and testbench

I2S_APB_MASTER -- requirements
Module: i2s_apb_master

---
 rtl/ctrl_pkg.sv | 20 ++
 rtl/i2s_apb_master.sv | 200 ++++++++++++++++++++
 tb/tb_i2s_apb_master.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Register map and FSM types for the I2S APB master.
package ctrl_pkg;

  localparam logic [31:0] ADDR_TX_DATA = 32'h0000_0000;
  localparam logic [31:0] ADDR_CTRL    = 32'h0000_0004;
  localparam logic [31:0] ADDR_RX_DATA = 32'h0000_0008;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_CFG = 2'd0,
    SRC_TX  = 2'd1,
    SRC_RX  = 2'd2
  } src_e;

endpackage

// File: rtl/i2s_apb_master.sv
// APB requester for an I2S peripheral: CTRL writes, TX pushes, RX reads.
// Define I2S_APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without pready.
module i2s_apb_master
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        cfg_load,
  input  logic [31:0] cfg_word,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  output logic        tx_ready,
  input  logic        rx_req,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  output logic        busy,
  output logic        err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready
);

  if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e state_q, state_d;
  src_e   src_q, src_d;

  logic cfg_pend_q, cfg_pend_d;
  logic tx_pend_q, tx_pend_d;
  logic rx_pend_q, rx_pend_d;

  logic [31:0] cfg_buf_q, tx_buf_q;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] rx_data_q;
  logic        rx_valid_q;
  logic        rdy_en_q;

  logic xfer_done, abort, xfer_end;
  logic cfg_clr, tx_clr, rx_clr;
  logic cfg_acc, tx_acc, rx_acc;
  logic any_pend, start;

  assign xfer_done = (state_q == ACCESS) && pready;
  assign xfer_end  = xfer_done || abort;

  assign cfg_clr = xfer_end && (src_q == SRC_CFG);
  assign tx_clr  = xfer_end && (src_q == SRC_TX);
  assign rx_clr  = xfer_end && (src_q == SRC_RX);

  // A flag clearing this cycle frees its slot for a same-cycle request.
  assign cfg_acc = cfg_load && (!cfg_pend_q || cfg_clr);
  assign tx_acc  = tx_valid && tx_ready;
  assign rx_acc  = rx_req && (!rx_pend_q || rx_clr);

  assign cfg_pend_d = (cfg_pend_q && !cfg_clr) || cfg_acc;
  assign tx_pend_d  = (tx_pend_q && !tx_clr) || tx_acc;
  assign rx_pend_d  = (rx_pend_q && !rx_clr) || rx_acc;

  assign any_pend = cfg_pend_q || tx_pend_q || rx_pend_q;
  assign start    = (state_q == IDLE) && any_pend;

  assign tx_ready = rdy_en_q && !tx_pend_q;
  assign busy     = (state_q != IDLE) || any_pend;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef I2S_APB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] tmo_q;
  logic          err_q;

  assign abort = (state_q == ACCESS) && !pready &&
                 (tmo_q == CW'(TIMEOUT_CYCLES - 1));
  assign err   = err_q;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q != ACCESS) tmo_q <= '0;
      else if (!pready)      tmo_q <= tmo_q + 1'b1;
      if (abort) err_q <= 1'b1;
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_pend) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    unique case (state_q)
      SETUP: begin
        psel   = 1'b1;
        pwrite = pwrite_q;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = pwrite_q;
      end
      default: ;
    endcase
  end

  // Fixed priority cfg > tx > rx, decided once per transfer in IDLE.
  always_comb begin
    src_d = src_q;
    if (cfg_pend_q)     src_d = SRC_CFG;
    else if (tx_pend_q) src_d = SRC_TX;
    else if (rx_pend_q) src_d = SRC_RX;
  end

  always_comb begin
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    if (start) begin
      unique case (src_d)
        SRC_CFG: begin
          paddr_d  = ADDR_CTRL;
          pwdata_d = cfg_buf_q;
          pwrite_d = 1'b1;
        end
        SRC_TX: begin
          paddr_d  = ADDR_TX_DATA;
          pwdata_d = tx_buf_q;
          pwrite_d = 1'b1;
        end
        SRC_RX: begin
          paddr_d  = ADDR_RX_DATA;
          pwrite_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      src_q      <= SRC_CFG;
      cfg_pend_q <= 1'b0;
      tx_pend_q  <= 1'b0;
      rx_pend_q  <= 1'b0;
      cfg_buf_q  <= '0;
      tx_buf_q   <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      rdy_en_q   <= 1'b1;
      cfg_pend_q <= cfg_pend_d;
      tx_pend_q  <= tx_pend_d;
      rx_pend_q  <= rx_pend_d;
      if (start)   src_q     <= src_d;
      if (cfg_acc) cfg_buf_q <= cfg_word;
      if (tx_acc)  tx_buf_q  <= tx_data;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      rx_valid_q <= xfer_done && (src_q == SRC_RX);
      if (xfer_done && (src_q == SRC_RX)) rx_data_q <= prdata;
    end
  end

endmodule

// File: tb/tb_i2s_apb_master.sv
// Directed bench for i2s_apb_master: vector table plus corner sequences.
module tb_i2s_apb_master;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        cfg_load = 1'b0;
  logic [31:0] cfg_word = '0;
  logic        tx_valid = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_ready;
  logic        rx_req = 1'b0;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        busy;
  logic        err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready;

  i2s_apb_master #(.TIMEOUT_CYCLES(16)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .cfg_load (cfg_load),
    .cfg_word (cfg_word),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_req   (rx_req),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .err      (err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          alen;
    int          cyc;
  } xfer_t;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [31:0] rdata;
    int          wt;
    logic [31:0] e_addr;
    logic        e_wr;
    int          e_alen;
  } vec_t;

  xfer_t log_q[$];
  int    wait_n = 0;
  int    alen = 0;
  int    cyc = 0;
  int    rv_cnt = 0;
  int    n_chk = 0;
  int    n_pass = 0;

  // Completer: holds pready low for wait_n ACCESS cycles.
  assign pready = penable && (alen >= wait_n);

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) alen <= 0;
    else if (penable && pready) begin
      log_q.push_back('{paddr, pwrite, pwdata, alen + 1, cyc});
      alen <= 0;
    end else if (penable) alen <= alen + 1;
    else alen <= 0;
  end

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (rx_valid) rv_cnt <= rv_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic issue(input int kind, input logic [31:0] d);
    case (kind)
      0: begin cfg_load = 1'b1; cfg_word = d; end
      1: begin tx_valid = 1'b1; tx_data = d; end
      default: rx_req = 1'b1;
    endcase
    tick;
    cfg_load = 1'b0;
    tx_valid = 1'b0;
    rx_req   = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 100) begin
      tick;
      k++;
    end
    chk(nm, busy, 1'b0);
  endtask

  function automatic logic [127:0] all_outs();
    return {psel, penable, pwrite, tx_ready, rx_valid, err, busy,
            paddr, pwdata, rx_data};
  endfunction

  vec_t vec[6];

  initial begin
    int b, r, acnt, k;

    vec[0] = '{0, 32'h0000_1081, 32'h0,         0, 32'h4, 1'b1, 1};
    vec[1] = '{1, 32'hDEAD_BEEF, 32'h0,         0, 32'h0, 1'b1, 1};
    vec[2] = '{2, 32'h0,         32'h1234_5678, 3, 32'h8, 1'b0, 4};
    vec[3] = '{1, 32'hA5A5_0F0F, 32'h0,         2, 32'h0, 1'b1, 3};
    vec[4] = '{2, 32'h0,         32'hFFFF_0001, 0, 32'h8, 1'b0, 1};
    vec[5] = '{0, 32'h8000_0000, 32'h0,         1, 32'h4, 1'b1, 2};

    // Reset state and tx_ready release timing
    tick;
    tick;
    chk("reset_outs", all_outs(), '0);
    preset_n = 1'b1;
    #1;
    chk("txrdy_before_edge", tx_ready, 1'b0);
    tick;
    chk("txrdy_after_release", tx_ready, 1'b1);

    // CTRL write cycle-by-cycle
    cfg_load = 1'b1;
    cfg_word = 32'h0000_1081;
    tick;
    cfg_load = 1'b0;
    chk("cfg_c0_psel_busy", {psel, busy}, 2'b01);
    tick;
    chk("cfg_c1_setup", {psel, penable, pwrite, paddr, pwdata},
        {3'b101, 32'h4, 32'h0000_1081});
    tick;
    chk("cfg_c2_access", {psel, penable, pwrite, paddr, pwdata},
        {3'b111, 32'h4, 32'h0000_1081});
    tick;
    chk("cfg_c3_idle", {busy, psel, penable, pwrite, paddr},
        {4'b0000, 32'h4});

    // Table-driven single transfers
    for (int i = 0; i < 6; i++) begin
      b = log_q.size();
      r = rv_cnt;
      wait_n = vec[i].wt;
      prdata = vec[i].rdata;
      if (vec[i].kind == 1) chk($sformatf("v%0d_txrdy_pre", i), tx_ready, 1'b1);
      issue(vec[i].kind, vec[i].data);
      if (vec[i].kind == 1) chk($sformatf("v%0d_txrdy_low", i), tx_ready, 1'b0);
      wait_idle($sformatf("v%0d_idle", i));
      tick;
      tick;
      chk($sformatf("v%0d_nxfer", i), log_q.size() - b, 1);
      if (log_q.size() > b) begin
        chk($sformatf("v%0d_addr", i), log_q[b].addr, vec[i].e_addr);
        chk($sformatf("v%0d_pwrite", i), log_q[b].wr, vec[i].e_wr);
        chk($sformatf("v%0d_alen", i), log_q[b].alen, vec[i].e_alen);
        if (vec[i].e_wr) chk($sformatf("v%0d_wdata", i), log_q[b].wdata, vec[i].data);
      end
      chk($sformatf("v%0d_rxvalid_n", i), rv_cnt - r, (vec[i].kind == 2) ? 1 : 0);
      if (vec[i].kind == 2) chk($sformatf("v%0d_rxdata", i), rx_data, vec[i].rdata);
      chk($sformatf("v%0d_txrdy_post", i), tx_ready, 1'b1);
    end

    // All three requests together: cfg, tx, rx order with 3-cycle spacing
    wait_n = 0;
    prdata = 32'h0BAD_F00D;
    b = log_q.size();
    r = rv_cnt;
    cfg_load = 1'b1; cfg_word = 32'h0000_00C3;
    tx_valid = 1'b1; tx_data = 32'h5555_AAAA;
    rx_req = 1'b1;
    tick;
    cfg_load = 1'b0; tx_valid = 1'b0; rx_req = 1'b0;
    wait_idle("all3_idle");
    tick;
    tick;
    chk("all3_nxfer", log_q.size() - b, 3);
    if (log_q.size() >= b + 3) begin
      chk("all3_addrs", {log_q[b].addr, log_q[b+1].addr, log_q[b+2].addr},
          {32'h4, 32'h0, 32'h8});
      chk("all3_wdata", {log_q[b].wdata, log_q[b+1].wdata},
          {32'h0000_00C3, 32'h5555_AAAA});
      chk("all3_gap01", log_q[b+1].cyc - log_q[b].cyc, 3);
      chk("all3_gap12", log_q[b+2].cyc - log_q[b+1].cyc, 3);
    end
    chk("all3_rx", {rv_cnt - r, rx_data}, {32'd1, 32'h0BAD_F00D});

    // Repeat cfg while pending is dropped; one on the clearing cycle is kept
    b = log_q.size();
    cfg_load = 1'b1; cfg_word = 32'h1111_0001;
    tick;
    cfg_word = 32'h2222_0002;
    tick;
    cfg_load = 1'b0;
    tick;
    cfg_load = 1'b1; cfg_word = 32'h3333_0003;
    tick;
    cfg_load = 1'b0;
    wait_idle("cfgrep_idle");
    chk("cfgrep_nxfer", log_q.size() - b, 2);
    if (log_q.size() >= b + 2)
      chk("cfgrep_wdata", {log_q[b].wdata, log_q[b+1].wdata},
          {32'h1111_0001, 32'h3333_0003});

    // Reset in the middle of ACCESS
    wait_n = 1000;
    prdata = 32'hCAFE_0123;
    b = log_q.size();
    r = rv_cnt;
    issue(2, 32'h0);
    k = 0;
    while (!penable && k < 10) begin
      tick;
      k++;
    end
    chk("rst_mid_in_access", penable, 1'b1);
    tick;
    preset_n = 1'b0;
    #1;
    chk("rst_mid_outs", all_outs(), '0);
    tick;
    preset_n = 1'b1;
    wait_n = 0;
    repeat (5) tick;
    chk("rst_mid_no_rxvalid", rv_cnt - r, 0);
    chk("rst_mid_no_xfer", log_q.size() - b, 0);
    chk("rst_mid_quiet", {busy, psel, tx_ready}, 3'b001);

`ifdef I2S_APB_TIMEOUT_EN
    // Stalled completer: abort after 16 ACCESS cycles, err sticky
    wait_n = 1000;
    r = rv_cnt;
    issue(2, 32'h0);
    acnt = 0;
    k = 0;
    while (busy && k < 80) begin
      if (penable) acnt++;
      tick;
      k++;
    end
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_access_len", acnt, 16);
    chk("tmo_err", err, 1'b1);
    tick;
    tick;
    chk("tmo_no_rxvalid", rv_cnt - r, 0);
    wait_n = 0;
    issue(0, 32'h0000_0077);
    wait_idle("tmo_after_idle");
    chk("tmo_err_sticky", err, 1'b1);
    preset_n = 1'b0;
    #1;
    chk("tmo_err_reset", err, 1'b0);
    tick;
    preset_n = 1'b1;
    tick;
`else
    chk("err_tied0", err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
